// File: rtl/alu_seq.sv
// alu_seq: integer execution unit with valid/ready handshakes on both sides.
// Define ALU_MULDIV_EN to build the iterative RV32M multiply/divide datapath.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ALU_ADD  = 5'd0;
  localparam logic [4:0] OP_ALU_SUB  = 5'd1;
  localparam logic [4:0] OP_ALU_SLL  = 5'd2;
  localparam logic [4:0] OP_ALU_SLT  = 5'd3;
  localparam logic [4:0] OP_ALU_SLTU = 5'd4;
  localparam logic [4:0] OP_ALU_XOR  = 5'd5;
  localparam logic [4:0] OP_ALU_SRL  = 5'd6;
  localparam logic [4:0] OP_ALU_SRA  = 5'd7;
  localparam logic [4:0] OP_ALU_OR   = 5'd8;
  localparam logic [4:0] OP_ALU_AND  = 5'd9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             accept;
  logic [WIDTH-1:0] base_res;
  logic             base_ok;

  assign in_ready  = rst_n && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign err       = err_q;

  always_comb begin
    base_ok  = 1'b1;
    base_res = '0;
    case (op)
      OP_ALU_ADD:  base_res = rs1 + rs2;
      OP_ALU_SUB:  base_res = rs1 - rs2;
      OP_ALU_SLL:  base_res = rs1 << rs2[SHW-1:0];
      OP_ALU_SRL:  base_res = rs1 >> rs2[SHW-1:0];
      OP_ALU_SRA:  base_res = $signed(rs1) >>> rs2[SHW-1:0];
      OP_ALU_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      OP_ALU_SLTU: base_res = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
      OP_ALU_XOR:  base_res = rs1 ^ rs2;
      OP_ALU_OR:   base_res = rs1 | rs2;
      OP_ALU_AND:  base_res = rs1 & rs2;
      default:     base_ok  = 1'b0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [4:0] OP_ALU_MUL    = 5'd10;
  localparam logic [4:0] OP_ALU_MULH   = 5'd11;
  localparam logic [4:0] OP_ALU_MULHSU = 5'd12;
  localparam logic [4:0] OP_ALU_MULHU  = 5'd13;
  localparam logic [4:0] OP_ALU_DIV    = 5'd14;
  localparam logic [4:0] OP_ALU_DIVU   = 5'd15;
  localparam logic [4:0] OP_ALU_REM    = 5'd16;
  localparam logic [4:0] OP_ALU_REMU   = 5'd17;
  localparam logic [1:0] S_MUL = 2'd1;
  localparam logic [1:0] S_DIV = 2'd2;
  localparam int CW = SHW + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // hi/lo hold {product} for MUL and {remainder, quotient} for DIV
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [4:0]         op_q, op_d;
  logic               neg_q, neg_d, rneg_q, rneg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [WIDTH-1:0]   step_hi, step_lo, quo, rem, iter_res;
  logic [2*WIDTH-1:0] prod;
  logic               a_signed, b_signed, a_neg, b_neg, is_mul, is_div, div_special;
  logic [WIDTH-1:0]   a_mag, b_mag, special_res;

  always_comb begin
    is_mul   = (op == OP_ALU_MUL) || (op == OP_ALU_MULH) || (op == OP_ALU_MULHSU) || (op == OP_ALU_MULHU);
    is_div   = (op == OP_ALU_DIV) || (op == OP_ALU_DIVU) || (op == OP_ALU_REM) || (op == OP_ALU_REMU);
    a_signed = (op == OP_ALU_MUL) || (op == OP_ALU_MULH) || (op == OP_ALU_MULHSU) ||
               (op == OP_ALU_DIV) || (op == OP_ALU_REM);
    b_signed = (op == OP_ALU_MUL) || (op == OP_ALU_MULH) || (op == OP_ALU_DIV) || (op == OP_ALU_REM);
    a_neg    = a_signed && rs1[WIDTH-1];
    b_neg    = b_signed && rs2[WIDTH-1];
    a_mag    = a_neg ? (~rs1 + 1'b1) : rs1;
    b_mag    = b_neg ? (~rs2 + 1'b1) : rs2;
    div_special = 1'b0;
    special_res = '0;
    if (rs2 == '0) begin
      div_special = 1'b1;
      special_res = (op == OP_ALU_DIV || op == OP_ALU_DIVU) ? '1 : rs1;
    end else if ((op == OP_ALU_DIV || op == OP_ALU_REM) && rs1 == MOST_NEG && rs2 == '1) begin
      div_special = 1'b1;
      special_res = (op == OP_ALU_DIV) ? rs1 : '0;
    end
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (state_q == S_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      step_hi = div_trial[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      step_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
    prod = neg_q ? (~{step_hi, step_lo} + 1'b1) : {step_hi, step_lo};
    quo  = neg_q ? (~step_lo + 1'b1) : step_lo;
    rem  = rneg_q ? (~step_hi + 1'b1) : step_hi;
    case (op_q)
      OP_ALU_MUL:                             iter_res = prod[WIDTH-1:0];
      OP_ALU_MULH, OP_ALU_MULHSU, OP_ALU_MULHU: iter_res = prod[2*WIDTH-1:WIDTH];
      OP_ALU_DIV, OP_ALU_DIVU:                iter_res = quo;
      default:                                iter_res = rem;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
`ifdef ALU_MULDIV_EN
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    op_d   = op_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    cnt_d  = cnt_q;
    if (state_q == S_MUL || state_q == S_DIV) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d  = S_DONE;
        result_d = iter_res;
        err_d    = 1'b0;
      end
    end
`endif
    if (state_q == S_DONE && out_ready) state_d = S_IDLE;
    if (accept) begin
      state_d  = S_DONE;
      err_d    = !base_ok;
      result_d = base_ok ? base_res : '0;
`ifdef ALU_MULDIV_EN
      if (is_mul || (is_div && !div_special)) begin
        state_d = is_mul ? S_MUL : S_DIV;
        err_d   = 1'b0;
        hi_d    = '0;
        lo_d    = a_mag;
        opnd_d  = b_mag;
        op_d    = op;
        neg_d   = a_neg ^ b_neg;
        rneg_d  = a_neg;
        cnt_d   = '0;
      end else if (is_div) begin
        err_d    = 1'b0;
        result_d = special_res;
      end
`endif
    end
    // flush drops anything in flight, including a result waiting in DONE
    if (flush) begin
      state_d = S_IDLE;
`ifdef ALU_MULDIV_EN
      cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef ALU_MULDIV_EN
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef ALU_MULDIV_EN
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      op_q   <= op_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      cnt_q  <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32), directed steps then random ops
// checked against an arithmetic reference model; follows ALU_MULDIV_EN.
module tb_alu_seq;
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3, SLTU = 5'd4;
  localparam logic [4:0] XOR = 5'd5, SRL = 5'd6, SRA = 5'd7, OR = 5'd8, AND = 5'd9;
  localparam logic [4:0] MUL = 5'd10, MULH = 5'd11, MULHSU = 5'd12, MULHU = 5'd13;
  localparam logic [4:0] DIV = 5'd14, DIVU = 5'd15, REM = 5'd16, REMU = 5'd17;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, err;
  logic [4:0]  op;
  logic [31:0] rs1, rs2, result;
  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference: result, err and latency straight from the RV32M arithmetic rules
  function automatic void model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int lat);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    r = '0; e = 1'b0; lat = 1; p = '0;
    case (o)
      ADD:  r = a + b;
      SUB:  r = a - b;
      SLL:  r = a << (b % 32);
      SRL:  r = a >> (b % 32);
      SRA:  begin p = 64'(sa >>> (b % 32)); r = p[31:0]; end
      SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
      XOR:  r = a ^ b;
      OR:   r = a | b;
      AND:  r = a & b;
`ifdef ALU_MULDIV_EN
      MUL:    begin p = 64'(sa * sb); r = p[31:0];  lat = 33; end
      MULH:   begin p = 64'(sa * sb); r = p[63:32]; lat = 33; end
      MULHSU: begin p = 64'(sa * ub); r = p[63:32]; lat = 33; end
      MULHU:  begin p = 64'(ua * ub); r = p[63:32]; lat = 33; end
      DIV:  if (b == 0) r = '1; else if (a == MIN && b == '1) r = a;
            else begin p = 64'(sa / sb); r = p[31:0]; lat = 33; end
      DIVU: if (b == 0) r = '1; else begin r = a / b; lat = 33; end
      REM:  if (b == 0) r = a; else if (a == MIN && b == '1) r = '0;
            else begin p = 64'(sa % sb); r = p[31:0]; lat = 33; end
      REMU: if (b == 0) r = a; else begin r = a % b; lat = 33; end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, check latency/result/err/busy
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] er;
    logic ee;
    int el, lat;
    bit busy_ok;
    model(o, a, b, er, ee, el);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    $display("[TB] %s op=%0d rs1=%08h rs2=%08h -> result=%08h err=%0b lat=%0d", tag, o, a, b, result, err, lat);
    check({tag, " latency"}, 32'(lat), 32'(el));
    check({tag, " result"}, result, er);
    check({tag, " err"}, 32'(err), 32'(ee));
    if (el > 1) check({tag, " busy in_ready"}, 32'(busy_ok), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] er;
    logic ee;
    int el;
    bit seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; rs1 = '0; rs2 = '0;

    repeat (3) begin
      @(posedge clk); #1;
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", result, 32'd0);
      check("reset err", 32'(err), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    check("post-reset out_valid", 32'(out_valid), 32'd0);

    // Three back-to-back base ops, one result per cycle
    op = ADD; rs1 = 32'hFFFF_FFFF; rs2 = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    model(ADD, 32'hFFFF_FFFF, 32'd1, er, ee, el);
    $display("[TB] b2b ADD -> valid=%0b result=%08h", out_valid, result);
    check("b2b ADD valid", 32'(out_valid), 32'd1);
    check("b2b ADD result", result, er);
    op = SRA; rs1 = MIN; rs2 = 32'h21;
    @(posedge clk); #1;
    model(SRA, MIN, 32'h21, er, ee, el);
    $display("[TB] b2b SRA -> valid=%0b result=%08h", out_valid, result);
    check("b2b SRA valid", 32'(out_valid), 32'd1);
    check("b2b SRA result", result, er);
    op = SLT; rs1 = 32'hFFFF_FFFF; rs2 = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model(SLT, 32'hFFFF_FFFF, 32'd1, er, ee, el);
    $display("[TB] b2b SLT -> valid=%0b result=%08h", out_valid, result);
    check("b2b SLT valid", 32'(out_valid), 32'd1);
    check("b2b SLT result", result, er);

    run_op(MULH, MIN, MIN, "mulh_min");
    run_op(DIV, MIN, 32'hFFFF_FFFF, "div_ovf");
    run_op(REM, 32'd7, 32'd0, "rem_by0");
    run_op(MUL, 32'd3, 32'd4, "mul_3x4");
    run_op(5'd25, 32'd5, 32'd6, "illegal");

    // Hold the consumer off: result and err must stay put
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(DIVU, 32'd100, 32'd7, "divu_hold");
    model(DIVU, 32'd100, 32'd7, er, ee, el);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      $display("[TB] hold cycle %0d valid=%0b result=%08h", i, out_valid, result);
      check("hold valid", 32'(out_valid), 32'd1);
      check("hold result", result, er);
      check("hold err", 32'(err), 32'(ee));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold retire", 32'(out_valid), 32'd0);

    // Flush a DIVU mid-flight (or while its result is pending)
    out_ready = 1'b0;
    @(negedge clk);
    op = DIVU; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    $display("[TB] flush -> valid=%0b in_ready=%0b", out_valid, in_ready);
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush no late result", 32'(seen), 32'd0);

    // in_valid together with flush is not accepted
    @(negedge clk);
    op = ADD; rs1 = 32'd1; rs2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    $display("[TB] flush+in_valid -> valid=%0b", out_valid);
    check("flush beats in_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [4:0] ro;
      ro = 5'($urandom_range(0, 20));
      run_op(ro, pick(), pick(), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
